ssm_group_sched: RTL and testbench



---
 rtl/ssm_pkg.sv | 26 ++
 rtl/ssm_y_fifo.sv | 52 +++++
 rtl/ssm_group_sched.sv | 174 +++++++++++++++++
 tb/tb_ssm_group_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssm_pkg.sv
// Shared definitions for the SSM group scheduler: group sizing helpers,
// counter widths for the default configuration and the FSM state encoding.
package ssm_pkg;

  // Tiles per group for a given group/tile lane split.
  function automatic int calc_tpg(input int n_total, input int n_tile);
    return n_total / n_tile;
  endfunction

  // Counter width able to index n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TPG_DEF        = calc_tpg(128, 16);
  localparam int TILE_CNT_W_DEF = cnt_w(TPG_DEF);
  localparam int CREDIT_W_DEF   = $clog2(4 + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ssm_y_fifo.sv
// Count-based result FIFO. Data is read from registered storage, so a push
// becomes visible at the head one cycle later. Full/empty are exported;
// the parent decides what an overflow means.
module ssm_y_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous push/pop when full reuses the slot being vacated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ssm_group_sched.sv
// Group scheduler and result collector for the SSM block datapath. Issues
// upstream tiles in groups, holds per-group scalars, limits groups in flight
// with credits and collects each group's result into a small FIFO.
module ssm_group_sched
  import ssm_pkg::*;
#(
  parameter int DW         = 16,
  parameter int N_TILE     = 16,
  parameter int N_TOTAL    = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int GRP_W      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [GRP_W-1:0]     num_groups_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DW-1:0]        s_dt_i,
  input  logic [DW-1:0]        s_dA_i,
  input  logic [DW-1:0]        s_x_i,
  input  logic [DW-1:0]        s_D_i,
  input  logic [N_TILE*DW-1:0] s_B_i,
  input  logic [N_TILE*DW-1:0] s_C_i,
  input  logic [N_TILE*DW-1:0] s_hprev_i,
  input  logic                 tile_ready_i,
  output logic                 tile_valid_o,
  output logic [DW-1:0]        dt_o,
  output logic [DW-1:0]        dA_o,
  output logic [DW-1:0]        x_o,
  output logic [DW-1:0]        D_o,
  output logic [N_TILE*DW-1:0] B_tile_o,
  output logic [N_TILE*DW-1:0] C_tile_o,
  output logic [N_TILE*DW-1:0] hprev_tile_o,
  input  logic [DW-1:0]        y_final_i,
  input  logic                 y_final_valid_i,
  output logic                 m_y_valid_o,
  input  logic                 m_y_ready_i,
  output logic [DW-1:0]        m_y_o,
  output logic [GRP_W-1:0]     m_y_idx_o
);

  localparam int TPG = calc_tpg(N_TOTAL, N_TILE);
  localparam int TCW = cnt_w(TPG);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  state_t           state_q, state_d;
  logic [GRP_W-1:0] num_groups_q;
  logic [TCW-1:0]   tile_cnt_q;
  logic [GRP_W-1:0] grp_issued_q;
  logic [GRP_W-1:0] grp_recv_q;
  logic [CW-1:0]    credits_q;
  logic             err_q;
  logic             zero_done_q;

  logic s_fire, first_tile, last_tile, last_group, start_ok;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty, res_in_idle, overflow;
  logic [DW+GRP_W-1:0] fifo_dout;

  assign first_tile  = (tile_cnt_q == '0);
  assign last_tile   = (tile_cnt_q == TCW'(TPG - 1));
  assign last_group  = ((grp_issued_q + GRP_W'(1)) == num_groups_q);
  assign start_ok    = (state_q == ST_IDLE) & start_i;
  assign s_ready_o   = (state_q == ST_RUN) & tile_ready_i & (grp_issued_q < num_groups_q)
                     & (~first_tile | (credits_q != '0));
  assign s_fire      = s_valid_i & s_ready_o;
  assign m_y_valid_o = ~fifo_empty;
  assign fifo_pop    = m_y_valid_o & m_y_ready_i;
  assign res_in_idle = y_final_valid_i & (state_q == ST_IDLE);
  assign overflow    = y_final_valid_i & (state_q != ST_IDLE) & fifo_full & ~fifo_pop;
  assign fifo_push   = y_final_valid_i & (state_q != ST_IDLE) & ~overflow;
  assign busy_o      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE) | zero_done_q;
  assign err_o       = err_q;
  assign m_y_o       = fifo_dout[DW+GRP_W-1:GRP_W];
  assign m_y_idx_o   = fifo_dout[GRP_W-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: run until the last tile issues, then drain until every result has left the FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok && num_groups_i != '0) state_d = ST_RUN;
      ST_RUN:   if (s_fire && last_tile && last_group) state_d = ST_DRAIN;
      ST_DRAIN: if (grp_recv_q == num_groups_q && fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Run bookkeeping: tile/group counters, credits and the sticky error (a set beats a clear).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      num_groups_q <= '0;
      tile_cnt_q   <= '0;
      grp_issued_q <= '0;
      grp_recv_q   <= '0;
      credits_q    <= '0;
      err_q        <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      zero_done_q <= start_ok & (num_groups_i == '0);
      if (start_ok) begin
        err_q <= 1'b0;
        if (num_groups_i != '0) begin
          num_groups_q <= num_groups_i;
          tile_cnt_q   <= '0;
          grp_issued_q <= '0;
          grp_recv_q   <= '0;
          credits_q    <= CW'(FIFO_DEPTH);
        end
      end else begin
        if (s_fire) begin
          tile_cnt_q <= last_tile ? '0 : tile_cnt_q + 1'b1;
          if (last_tile) grp_issued_q <= grp_issued_q + 1'b1;
        end
        if ((s_fire && first_tile) && !fifo_pop)      credits_q <= credits_q - 1'b1;
        else if (fifo_pop && !(s_fire && first_tile)) credits_q <= credits_q + 1'b1;
        if (fifo_push) grp_recv_q <= grp_recv_q + 1'b1;
      end
      if (res_in_idle || overflow) err_q <= 1'b1;
    end
  end

  // Datapath issue register: vectors load every fire, scalars only on a group's first tile.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_valid_o <= 1'b0;
      dt_o         <= '0;
      dA_o         <= '0;
      x_o          <= '0;
      D_o          <= '0;
      B_tile_o     <= '0;
      C_tile_o     <= '0;
      hprev_tile_o <= '0;
    end else begin
      tile_valid_o <= s_fire;
      if (s_fire) begin
        B_tile_o     <= s_B_i;
        C_tile_o     <= s_C_i;
        hprev_tile_o <= s_hprev_i;
        if (first_tile) begin
          dt_o <= s_dt_i;
          dA_o <= s_dA_i;
          x_o  <= s_x_i;
          D_o  <= s_D_i;
        end
      end
    end
  end

  ssm_y_fifo #(
    .W     (DW + GRP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_y_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({y_final_i, grp_recv_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ssm_group_sched.sv
// Self-checking bench for ssm_group_sched: a table of tiles for the scalar
// hold behaviour, scoreboards for issued tiles and results, and hand-written
// sequences for credit stall, zero-length runs, spurious results and reset.
module tb_ssm_group_sched;

  localparam int DW = 16, N_TILE = 16, FIFO_DEPTH = 4, GRP_W = 16, VW = N_TILE * DW;

  logic clk, rstn, start_i, busy_o, done_o, err_o, s_valid_i, s_ready_o;
  logic [GRP_W-1:0] num_groups_i, m_y_idx_o;
  logic [DW-1:0] s_dt_i, s_dA_i, s_x_i, s_D_i, dt_o, dA_o, x_o, D_o, y_final_i, m_y_o;
  logic [VW-1:0] s_B_i, s_C_i, s_hprev_i, B_tile_o, C_tile_o, hprev_tile_o;
  logic tile_ready_i, tile_valid_o, y_final_valid_i, m_y_valid_o, m_y_ready_i;

  ssm_group_sched #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(128), .FIFO_DEPTH(FIFO_DEPTH), .GRP_W(GRP_W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .num_groups_i(num_groups_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_dt_i(s_dt_i), .s_dA_i(s_dA_i), .s_x_i(s_x_i), .s_D_i(s_D_i),
    .s_B_i(s_B_i), .s_C_i(s_C_i), .s_hprev_i(s_hprev_i),
    .tile_ready_i(tile_ready_i), .tile_valid_o(tile_valid_o),
    .dt_o(dt_o), .dA_o(dA_o), .x_o(x_o), .D_o(D_o),
    .B_tile_o(B_tile_o), .C_tile_o(C_tile_o), .hprev_tile_o(hprev_tile_o),
    .y_final_i(y_final_i), .y_final_valid_i(y_final_valid_i),
    .m_y_valid_o(m_y_valid_o), .m_y_ready_i(m_y_ready_i),
    .m_y_o(m_y_o), .m_y_idx_o(m_y_idx_o)
  );

  typedef struct {
    logic [15:0] x, dt, dA, D;
    logic [VW-1:0] b, c, h;
    int fire_cyc;
  } tile_exp_t;

  typedef struct {
    logic [15:0] y;
    logic [15:0] idx;
  } res_exp_t;

  typedef struct {
    logic [15:0] x_in;
    logic [15:0] exp_x;
  } vec_row_t;

  tile_exp_t tile_q[$];
  res_exp_t  res_q[$];
  tile_exp_t cur_exp, mon_e;
  res_exp_t  mon_r;
  vec_row_t  tbl[16];
  int total, bad, cyc, res_idx, vec_seed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [VW-1:0] mkvec(input int seed);
    logic [VW-1:0] v;
    for (int l = 0; l < N_TILE; l++) v[l*DW +: DW] = 16'(seed * 37 + l);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: records fires, checks issued tiles and popped results.
  always @(negedge clk) begin
    cyc++;
    if (tile_valid_o) begin
      if (tile_q.size() == 0) check("tile_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = tile_q.pop_front();
        check("tile_latency", 64'(cyc), 64'(mon_e.fire_cyc + 1));
        check("x_o", x_o, mon_e.x);
        check("dt_o", dt_o, mon_e.dt);
        check("dA_o", dA_o, mon_e.dA);
        check("D_o", D_o, mon_e.D);
        check_vec("B_tile_o", B_tile_o, mon_e.b);
        check_vec("C_tile_o", C_tile_o, mon_e.c);
        check_vec("hprev_tile_o", hprev_tile_o, mon_e.h);
      end
    end
    if (s_valid_i && s_ready_o) begin
      mon_e = cur_exp;
      mon_e.fire_cyc = cyc;
      tile_q.push_back(mon_e);
    end
    if (m_y_valid_o && m_y_ready_i) begin
      if (res_q.size() == 0) check("result_unexpected", 64'd1, 64'd0);
      else begin
        mon_r = res_q.pop_front();
        check("m_y_o", m_y_o, mon_r.y);
        check("m_y_idx_o", m_y_idx_o, mon_r.idx);
      end
    end
  end

  task automatic set_tile(input logic [15:0] x_in, input logic [15:0] exp_x);
    vec_seed++;
    s_valid_i = 1'b1;
    s_x_i = x_in; s_dt_i = x_in + 16'd1; s_dA_i = x_in + 16'd2; s_D_i = x_in + 16'd3;
    s_B_i = mkvec(vec_seed); s_C_i = mkvec(vec_seed + 1000); s_hprev_i = mkvec(vec_seed + 2000);
    cur_exp.x = exp_x; cur_exp.dt = exp_x + 16'd1; cur_exp.dA = exp_x + 16'd2; cur_exp.D = exp_x + 16'd3;
    cur_exp.b = mkvec(vec_seed); cur_exp.c = mkvec(vec_seed + 1000); cur_exp.h = mkvec(vec_seed + 2000);
  endtask

  task automatic applyStimulus(input logic [15:0] x_in, input logic [15:0] exp_x);
    int n;
    @(posedge clk); #2;
    set_tile(x_in, exp_x);
    n = 0;
    @(negedge clk);
    while (!s_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      check("tile_accept_timeout", 64'd0, 64'd1);
      s_valid_i = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk); #2;
    s_valid_i = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    @(posedge clk); #2;
    start_i = 1'b1;
    num_groups_i = n;
    res_idx = 0;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic send_result(input logic [15:0] y);
    @(posedge clk); #2;
    y_final_valid_i = 1'b1;
    y_final_i = y;
    res_q.push_back('{y: y, idx: 16'(res_idx)});
    res_idx++;
    @(posedge clk); #2;
    y_final_valid_i = 1'b0;
  endtask

  task automatic spurious_result(input logic [15:0] y);
    @(posedge clk); #2;
    y_final_valid_i = 1'b1;
    y_final_i = y;
    @(posedge clk); #2;
    y_final_valid_i = 1'b0;
    @(negedge clk);
    check("err_after_spurious", err_o, 1);
    check("fifo_empty_after_spurious", m_y_valid_o, 0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_s_ready"}, s_ready_o, 0);
    check({tag, "_tile_valid"}, tile_valid_o, 0);
    check({tag, "_m_y_valid"}, m_y_valid_o, 0);
    check({tag, "_x"}, x_o, 0);
    check({tag, "_dt"}, dt_o, 0);
    check_vec({tag, "_B"}, B_tile_o, '0);
    check({tag, "_m_y"}, m_y_o, 0);
    check({tag, "_m_y_idx"}, m_y_idx_o, 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, done_o, 1);
    @(negedge clk);
    check({name, "_pulse_end"}, done_o, 0);
    check({name, "_busy_low"}, busy_o, 0);
  endtask

  task automatic send_group(input logic [15:0] x0, input logic [15:0] junk);
    for (int t = 0; t < 8; t++) applyStimulus((t == 0) ? x0 : junk, x0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; res_idx = 0; vec_seed = 0;
    rstn = 1'b0; start_i = 1'b0; num_groups_i = '0; s_valid_i = 1'b0;
    s_dt_i = '0; s_dA_i = '0; s_x_i = '0; s_D_i = '0;
    s_B_i = '0; s_C_i = '0; s_hprev_i = '0;
    tile_ready_i = 1'b1; y_final_i = '0; y_final_valid_i = 1'b0; m_y_ready_i = 1'b1;
    cur_exp = '{default: '0};

    for (int i = 0; i < 16; i++) begin
      if (i == 0)      tbl[i] = '{x_in: 16'h3C00, exp_x: 16'h3C00};
      else if (i < 3)  tbl[i] = '{x_in: 16'h1111, exp_x: 16'h3C00};
      else if (i < 8)  tbl[i] = '{x_in: 16'h4400, exp_x: 16'h3C00};
      else if (i == 8) tbl[i] = '{x_in: 16'h4800, exp_x: 16'h4800};
      else             tbl[i] = '{x_in: 16'h5555, exp_x: 16'h4800};
    end

    // Reset state
    @(negedge clk);
    checkOutput("reset");
    @(posedge clk); #2;
    rstn = 1'b1;

    // Zero-group run
    do_start(16'd0);
    @(negedge clk);
    check("zero_done_pulse", done_o, 1);
    check("zero_busy", busy_o, 0);
    @(negedge clk);
    check("zero_done_end", done_o, 0);
    check("zero_busy_after", busy_o, 0);

    // Spurious result in IDLE, then a single-group run that clears the error
    spurious_result(16'h1234);
    do_start(16'd1);
    @(negedge clk);
    check("err_cleared_by_start", err_o, 0);
    check("busy_single", busy_o, 1);
    send_group(16'h3C00, 16'h3C00);
    idle_inputs();
    send_result(16'h4000);
    wait_done("single_done");

    // Table-driven scalar hold across two groups
    do_start(16'd2);
    for (int i = 0; i < 16; i++) applyStimulus(tbl[i].x_in, tbl[i].exp_x);
    idle_inputs();
    send_result(16'h4100);
    send_result(16'h4200);
    wait_done("table_done");

    // Credit stall: four groups fill the FIFO with nothing popped
    m_y_ready_i = 1'b0;
    do_start(16'd6);
    for (int g = 0; g < 4; g++) send_group(16'h1000 + 16'(g), 16'hBEEF);
    idle_inputs();
    for (int g = 0; g < 4; g++) send_result(16'h2000 + 16'(g));
    @(posedge clk); #2;
    set_tile(16'h1004, 16'h1004);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready_low", s_ready_o, 0);
    end
    check("stall_err_clear", err_o, 0);
    check("stall_fifo_valid", m_y_valid_o, 1);
    @(posedge clk); #2;
    m_y_ready_i = 1'b1;
    @(negedge clk);
    check("stall_ready_before_pop", s_ready_o, 0);
    @(posedge clk); #2;
    m_y_ready_i = 1'b0;
    @(negedge clk);
    check("ready_after_pop", s_ready_o, 1);
    for (int t = 1; t < 8; t++) applyStimulus(16'hBEEF, 16'h1004);
    idle_inputs();
    m_y_ready_i = 1'b1;
    send_group(16'h1005, 16'hCAFE);
    idle_inputs();
    send_result(16'h2004);
    send_result(16'h2005);
    wait_done("credit_done");

    // Reset in the middle of group 2
    do_start(16'd3);
    send_group(16'h3000, 16'h7777);
    send_group(16'h3001, 16'h7777);
    for (int t = 0; t < 5; t++) applyStimulus((t == 0) ? 16'h3002 : 16'h7777, 16'h3002);
    idle_inputs();
    @(negedge clk);
    #1 rstn = 1'b0;
    #1 checkOutput("midreset");
    @(posedge clk); #2;
    rstn = 1'b1;
    spurious_result(16'h5A5A);
    do_start(16'd1);
    @(negedge clk);
    check("err_cleared_after_reset", err_o, 0);
    send_group(16'h3C00, 16'h6666);
    idle_inputs();
    send_result(16'h4000);
    wait_done("post_reset_done");

    check("tile_queue_drained", 64'(tile_q.size()), 0);
    check("result_queue_drained", 64'(res_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
